sevenseg_scanner: RTL and testbench
===================================

# sevenseg_scanner

Time-multiplexed 8-digit hexadecimal seven-segment driver that sits directly downstream of the memory-mapped output register and consumes its 32-bit `oport` word. Each frame, it latches the value into a shadow register and scans eight common-anode/cathode digits, one nibble per slot. A dead-time at the start of each slot suppresses ghosting. Optional leading-zero blanking and per-digit decimal points are provided.

## Interface
- `PRESCALE`, 50000: clk cycles per digit slot; legal range ≥ 4.
- `DEADTIME`, 2: cycles at the start of each slot with all anodes off; legal range 1 ≤ DEADTIME < PRESCALE.
- `ACTIVE_LOW_OUT`, 1: 1 = `seg`/`dp`/`an` active-low, 0 = active-high.
- `clk`, in, 1: single clock; all state on rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `value`, in, 32: word to display, connected to `oport`; nibble i drives digit i (digit 0 is rightmost).
- `dp_en`, in, 8: decimal point enable per digit.
- `blank_lz`, in, 1: leading-zero blanking enable.
- `seg`, out, 7: segments {g,f,e,d,c,b,a}, `seg[0]` = a.
- `dp`, out, 1: decimal point segment.
- `an`, out, 8: digit enables, `an[i]` = digit i.

## Operation
- State: prescale counter `p` (0..PRESCALE-1), digit index `d` (0..7), shadow regs `sv[31:0]`, `sdp[7:0]`, `slz`, flag `primed`.
- Slot tick: `p == PRESCALE-1` → `p` wraps to 0 and `d` increments. `d` wraps from 7 to 0.
- Shadow load occurs on either of these events, and `value`/`dp_en`/`blank_lz` are all captured in the same cycle:
  - `primed == 0`: first edge after reset; `primed` then sets to 1.
  - tick with `d == 7`: the end of the frame.
- Input changes between loads must not affect the display (no tearing).
- Hex decode (active-high form): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. If ACTIVE_LOW_OUT=1, all outputs are bitwise inverted.
- Leading-zero blank for digit i (i ≥ 1): `slz == 1` and `sv` nibbles i..7 are all zero. Digit 0 is never blanked.
- Blanked digit:
  - segments off.
  - `dp` = `sdp[i]`.
  - anode active only if `sdp[i] == 1`.
- Dead-time (`p < DEADTIME`): all anodes inactive, segments off, `dp` off.
- Otherwise exactly one anode is active (`an[d]`), and `seg`/`dp` reflect the decoded nibble `d` of `sv` and `sdp[d]`.

## Timing
- `seg`, `dp`, `an` are registered outputs. The value after edge k is the decode of the pre-edge (`p`, `d`, `sv`, `sdp`, `slz`), so there is 1 cycle latency from state to pins.
- Reset (async assert, any time including mid-frame):
  - `p` = 0, `d` = 0, `sv` = 0, `sdp` = 0, `slz` = 0, `primed` = 0.
  - all outputs go inactive immediately: `an` = all inactive, `seg` = off, `dp` = off. With ACTIVE_LOW_OUT=1 this is `an` = FF, `seg` = 7F, `dp` = 1.
- First edge after release (E1): shadow loads; outputs stay inactive, because `p` = 0 is dead-time.
- Slot length = PRESCALE cycles. Frame length = 8 × PRESCALE cycles.
- Digit i is lit on output cycles where the pre-edge `p` is in [DEADTIME, PRESCALE-1].
- A value written at any point of frame n is displayed starting with digit 0 of frame n+1. The exception is the first frame after reset, which shows the value sampled at E1.

## Test plan
Run with PRESCALE=4, DEADTIME=1, ACTIVE_LOW_OUT=1.
- **Reset:** hold `reset_n`=0, toggle `value` → `an`=FF, `seg`=7F, `dp`=1 throughout. Release → first lit cycle is E3 with `an`=FE.
- **Full scan:** `value`=1234ABCD, `blank_lz`=0, `dp_en`=00 → over 32 cycles, each digit lit 3 cycles, 1 dead cycle between digits:
  - digit 0 `seg`=~5E=21
  - digit 4 `seg`=~66=19
  - digit 7 `seg`=~06=79
- **Leading-zero blank:** `value`=000000A5, `blank_lz`=1 → digits 7..2 `an` stay inactive, digit 1 `seg`=~77=08, digit 0 `seg`=~6D=12. With `value`=0, only digit 0 is lit, `seg`=40.
- **No tearing:** change `value` from 11111111 to 22222222 while `d`=3 → remaining digits 4..7 of this frame still show 1 (`seg`=79). The next frame shows 2 (`seg`=24) starting at digit 0.
- **Decimal point on blanked digit:** `value`=00000001, `blank_lz`=1, `dp_en`=80 → digit 7 `an`=7F, `seg`=7F, `dp`=0. Digits 6..1 are fully off.
- **Mid-frame reset:** assert `reset_n` while `d`=5 → outputs go inactive asynchronously. After release, the scan restarts at digit 0 with a freshly loaded shadow.

Source files
------------

// File: rtl/sevenseg_scanner.sv
// sevenseg_scanner: time-multiplexed 8-digit hex seven-segment driver.
// A shadow copy of value/dp_en/blank_lz is taken once per frame (and on the
// first edge after reset) so mid-frame input changes never tear the display.
// Each digit slot opens with DEADTIME cycles of all-anodes-off to stop ghosting.
//
// Ports:
//   clk      - clock, all state on rising edge
//   reset_n  - asynchronous active-low reset
//   value    - 32-bit word to display, nibble i on digit i (digit 0 rightmost)
//   dp_en    - per-digit decimal point enable
//   blank_lz - leading-zero blanking enable
//   seg      - registered segments {g,f,e,d,c,b,a}
//   dp       - registered decimal point segment
//   an       - registered digit enables, an[i] = digit i
module sevenseg_scanner #(
  parameter int unsigned PRESCALE       = 50000,
  parameter int unsigned DEADTIME       = 2,
  parameter int unsigned ACTIVE_LOW_OUT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] value,
  input  logic [7:0]  dp_en,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an
);

  localparam int unsigned PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] P_DEAD = PW'(DEADTIME);
  localparam logic          INV    = (ACTIVE_LOW_OUT != 0);

  logic [PW-1:0] p;
  logic [2:0]    d;
  logic [31:0]   sv;
  logic [7:0]    sdp;
  logic          slz;
  logic          primed;

  logic          tick_c;
  logic          load_c;
  logic [3:0]    nib_c;
  logic [7:0]    lz_c;
  logic          blank_c;
  logic [7:0]    onehot_c;
  logic [6:0]    seg_c;
  logic          dp_c;
  logic [7:0]    an_c;

  // Active-high hex to segment decode, bit 0 = segment a.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Slot tick and shadow-load strobe (priming edge or end of frame).
  always_comb begin
    tick_c = (p == P_LAST);
    load_c = !primed || (tick_c && (d == 3'd7));
  end

  // Decode of the current scan state into active-high pin values.
  always_comb begin
    seg_c    = 7'h00;
    dp_c     = 1'b0;
    an_c     = 8'h00;
    nib_c    = 4'(sv >> {d, 2'b00});
    onehot_c = 8'h01 << d;
    // lz_c[i]: nibbles i..7 of the shadow are all zero
    for (int i = 0; i < 8; i++) begin
      lz_c[i] = ((sv >> (4 * i)) == 32'd0);
    end
    blank_c = slz && (d != 3'd0) && lz_c[d];
    if (p >= P_DEAD) begin
      dp_c = sdp[d];
      if (blank_c) begin
        an_c = sdp[d] ? onehot_c : 8'h00;
      end else begin
        seg_c = hex7(nib_c);
        an_c  = onehot_c;
      end
    end
  end

  // Scan counters, shadow registers and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p      <= '0;
      d      <= 3'd0;
      sv     <= 32'd0;
      sdp    <= 8'd0;
      slz    <= 1'b0;
      primed <= 1'b0;
      seg    <= {7{INV}};
      dp     <= INV;
      an     <= {8{INV}};
    end else begin
      primed <= 1'b1;
      if (load_c) begin
        sv  <= value;
        sdp <= dp_en;
        slz <= blank_lz;
      end
      // The priming edge only loads the shadow; scanning starts on the next.
      if (primed) begin
        if (tick_c) begin
          p <= '0;
          d <= d + 3'd1;
        end else begin
          p <= p + PW'(1);
        end
      end
      seg <= seg_c ^ {7{INV}};
      dp  <= dp_c ^ INV;
      an  <= an_c ^ {8{INV}};
    end
  end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Directed bench for sevenseg_scanner at PRESCALE=4, DEADTIME=1, active-low pins.
module tb_sevenseg_scanner;

  logic        clk;
  logic        reset_n;
  logic [31:0] value;
  logic [7:0]  dp_en;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;

  int n_cmp = 0;
  int n_bad = 0;

  sevenseg_scanner #(
    .PRESCALE      (4),
    .DEADTIME      (1),
    .ACTIVE_LOW_OUT(1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .value   (value),
    .dp_en   (dp_en),
    .blank_lz(blank_lz),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame's worth of expected lit-phase pins, packed digit 7 first.
  typedef struct {
    logic [31:0]     value;
    logic [7:0]      dp_en;
    logic            blz;
    logic [7:0][6:0] seg;
    logic [7:0]      dp;
    logic [7:0][7:0] an;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic check(input string name, input int c, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%02h exp=%02h", name, c, got, exp);
    end
  endtask

  task automatic check_idle(input string name, input int c);
    check({name, "_an"}, c, an, 8'hFF);
    check({name, "_seg"}, c, {1'b0, seg}, 8'h7F);
    check({name, "_dp"}, c, {7'd0, dp}, 8'h01);
  endtask

  task automatic apply(input int k);
    value    = vecs[k].value;
    dp_en    = vecs[k].dp_en;
    blank_lz = vecs[k].blz;
  endtask

  // Reset with inputs toggling, release, then observe the priming edge E1.
  task automatic reset_start(input int k);
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      value = 32'hDEAD0000 + 32'(i);
      @(posedge clk); #1;
      check_idle("rst", i);
    end
    apply(k);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_idle("e1", 0);
  endtask

  // Check 32 output cycles of a frame; optionally change inputs during digit 3.
  task automatic check_frame(input int k, input int nxt);
    int dg;
    for (int c = 0; c < 32; c++) begin
      if (c == 13 && nxt >= 0) apply(nxt);
      @(posedge clk); #1;
      dg = c / 4;
      if ((c % 4) == 0) begin
        check_idle($sformatf("v%0d_dead", k), c);
      end else begin
        check($sformatf("v%0d_an", k), c, an, vecs[k].an[dg]);
        check($sformatf("v%0d_seg", k), c, {1'b0, seg}, {1'b0, vecs[k].seg[dg]});
        check($sformatf("v%0d_dp", k), c, {7'd0, dp}, {7'd0, vecs[k].dp[dg]});
      end
    end
  endtask

  initial begin
    localparam logic [7:0][7:0] AN_ALL = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    vecs[0] = '{32'h1234ABCD, 8'h00, 1'b0,
                {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21}, 8'hFF, AN_ALL};
    vecs[1] = '{32'h11111111, 8'h00, 1'b0, {8{7'h79}}, 8'hFF, AN_ALL};
    vecs[2] = '{32'h22222222, 8'h00, 1'b0, {8{7'h24}}, 8'hFF, AN_ALL};
    vecs[3] = '{32'h000000A5, 8'h00, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12}, 8'hFF,
                {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'hFE}};
    vecs[4] = '{32'h00000000, 8'h00, 1'b1, {{7{7'h7F}}, 7'h40}, 8'hFF, {{7{8'hFF}}, 8'hFE}};
    vecs[5] = '{32'h00000001, 8'h80, 1'b1, {{7{7'h7F}}, 7'h79}, 8'h7F,
                {8'h7F, {6{8'hFF}}, 8'hFE}};
    vecs[6] = '{32'h00000000, 8'h00, 1'b0, {8{7'h40}}, 8'hFF, AN_ALL};
    vecs[7] = '{32'hFEDC9876, 8'h5A, 1'b0,
                {7'h0E, 7'h06, 7'h21, 7'h46, 7'h10, 7'h00, 7'h78, 7'h02}, 8'hA5, AN_ALL};
    vecs[8] = '{32'h00F00000, 8'h01, 1'b1,
                {7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'hFE,
                {8'hFF, 8'hFF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE}};

    reset_n  = 1'b0;
    value    = 32'd0;
    dp_en    = 8'd0;
    blank_lz = 1'b0;

    // Table: each frame changes inputs mid-frame; the change shows next frame.
    reset_start(0);
    for (int k = 0; k < NV; k++) begin
      check_frame(k, (k + 1 < NV) ? k + 1 : -1);
    end

    // Mid-frame asynchronous reset while digit 5 is scanning.
    repeat (21) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_idle("midrst", 0);
    apply(7);
    @(posedge clk); #1;
    check_idle("midrst_hold", 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_idle("midrst_e1", 0);
    check_frame(7, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
